// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: conditions three raw buttons into one-cycle
// press pulses, runs the IDLE/RUN/LAP/STOP machine and prescales clk into count_en.
module stopwatch_ctrl #(
  parameter int TICK_DIV   = 1000000,
  parameter int DEB_CYCLES = 1000000,
  parameter int PRE_W      = 20,
  parameter int DEB_W      = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic       count_en,
  output logic       count_clr,
  output logic       display_hold,
  output logic       running,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAP  = 2'd2,
    STOP = 2'd3
  } state_t;

  localparam int BTN_SS  = 0;
  localparam int BTN_LAP = 1;
  localparam int BTN_CLR = 2;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [2:0]       btn_raw;
  logic [2:0]       sync0, sync1, stable, stable_d, press;
  logic [DEB_W-1:0] deb_cnt [3];

  state_t           state_q, state_nxt;
  logic [PRE_W-1:0] pre_q, pre_nxt;
  logic             clr_nxt;

  assign btn_raw = {btn_clear, btn_lap, btn_start_stop};

  // Button conditioning: 2-flop sync, debounce against the stable level, then
  // a registered rising-edge detect on the stable level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync0    <= '0;
      sync1    <= '0;
      stable   <= '0;
      stable_d <= '0;
      press    <= '0;
      // NOTE: the debounce counter array is cleared explicitly; it is flop-based
      // state that must restart a fresh debounce after reset, not a RAM.
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage see last cycle's value,
      // which is what makes sync0 -> sync1 a real two-flop chain.
      sync0    <= btn_raw;
      sync1    <= sync0;
      stable_d <= stable;
      press    <= stable & ~stable_d;
      for (int i = 0; i < 3; i++) begin
        if (sync1[i] != stable[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            stable[i]  <= sync1[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      count_clr <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      pre_q     <= pre_nxt;
      count_clr <= clr_nxt;
    end
  end

  // Each state tests only the presses it honours, in priority order, so a
  // higher-priority press that is invalid here never masks a valid one.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    state_nxt = state_q;
    pre_nxt   = pre_q;
    clr_nxt   = 1'b0;
    if (running) pre_nxt = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (press[BTN_CLR]) begin
          clr_nxt = 1'b1;
          pre_nxt = '0;
        end else if (press[BTN_SS]) begin
          state_nxt = RUN;
          pre_nxt   = '0;
        end
      end
      RUN: begin
        if (press[BTN_SS])       state_nxt = STOP;
        else if (press[BTN_LAP]) state_nxt = LAP;
      end
      LAP: begin
        if (press[BTN_SS])       state_nxt = STOP;
        else if (press[BTN_LAP]) state_nxt = RUN;
      end
      STOP: begin
        if (press[BTN_CLR]) begin
          state_nxt = IDLE;
          clr_nxt   = 1'b1;
          pre_nxt   = '0;
        end else if (press[BTN_SS]) begin
          state_nxt = RUN;  // prescaler kept: sub-tick fraction survives a stop
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign running      = (state_q == RUN) || (state_q == LAP);
  assign display_hold = (state_q == LAP);
  assign count_en     = running && (pre_q == PRE_LAST);
  assign state        = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: a cycle model feeds a scoreboard of
// expected outputs, plus directed latency/period checks.
module tb_stopwatch_ctrl;

  localparam int TICK = 4;
  localparam int DEB  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_start_stop, btn_lap, btn_clear;
  logic       count_en, count_clr, display_hold, running;
  logic [1:0] state;

  stopwatch_ctrl #(.TICK_DIV(TICK), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset),
    .btn_start_stop(btn_start_stop), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .count_en(count_en), .count_clr(count_clr), .display_hold(display_hold),
    .running(running), .state(state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [5:0] exp_q [$];

  // Reference model of the spec, index 0=start_stop, 1=lap, 2=clear
  bit m_s0[3], m_s1[3], m_st[3], m_std[3], m_pr[3];
  int m_cnt[3];
  int m_state, m_pre;
  bit m_clr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] model_outs();
    bit run_m = (m_state == 1) || (m_state == 2);
    return {run_m && (m_pre == TICK - 1), m_clr, m_state == 2, run_m, 2'(m_state)};
  endfunction

  task automatic model_step();
    bit raw[3];
    bit act_clr, act_ss, act_lap;
    int old_state;
    raw = '{btn_start_stop, btn_lap, btn_clear};
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        m_s0[i] = 0; m_s1[i] = 0; m_st[i] = 0; m_std[i] = 0; m_pr[i] = 0; m_cnt[i] = 0;
      end
      m_state = 0; m_pre = 0; m_clr = 0;
      return;
    end
    old_state = m_state;
    act_clr = m_pr[2] && (old_state == 0 || old_state == 3);
    act_ss  = !act_clr && m_pr[0];
    act_lap = !act_clr && !m_pr[0] && m_pr[1] && (old_state == 1 || old_state == 2);
    if (old_state == 1 || old_state == 2) m_pre = (m_pre + 1) % TICK;
    m_clr = act_clr;
    if (act_clr) begin
      m_state = 0; m_pre = 0;
    end else if (act_ss) begin
      if (old_state == 0) m_pre = 0;
      m_state = (old_state == 0 || old_state == 3) ? 1 : 3;
    end else if (act_lap) begin
      m_state = (old_state == 1) ? 2 : 1;
    end
    for (int i = 0; i < 3; i++) begin
      m_pr[i]  = m_st[i] && !m_std[i];
      m_std[i] = m_st[i];
      if (m_s1[i] != m_st[i]) begin
        m_cnt[i]++;
        if (m_cnt[i] == DEB) begin
          m_st[i] = m_s1[i]; m_cnt[i] = 0;
        end
      end else begin
        m_cnt[i] = 0;
      end
      m_s1[i] = m_s0[i];
      m_s0[i] = raw[i];
    end
  endtask

  // One clock: model and DUT see the same inputs at the edge; compare at negedge.
  task automatic cycle();
    logic [5:0] exp;
    @(posedge clk);
    model_step();
    exp_q.push_back(model_outs());
    @(negedge clk);
    exp = exp_q.pop_front();
    check("outs", {count_en, count_clr, display_hold, running, state}, exp);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, output int n);
    n = 0;
    while (state !== s && n < budget) begin cycle(); n++; end
  endtask

  task automatic wait_en(input int budget, output int n);
    n = 0;
    while (count_en !== 1'b1 && n < budget) begin cycle(); n++; end
  endtask

  // Clean press: hold long enough to debounce, then release and let it settle.
  task automatic press(input int idx);
    if (idx == 0) btn_start_stop = 1'b1;
    else if (idx == 1) btn_lap = 1'b1;
    else btn_clear = 1'b1;
    cycles(6);
    btn_start_stop = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
    cycles(7);
  endtask

  initial begin
    int n;
    int clr_seen;
    reset = 1'b1;
    btn_start_stop = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
    @(negedge clk);
    cycles(2);
    check("reset_outs", {count_en, count_clr, display_hold, running, state}, 6'b0);
    reset = 1'b0;
    cycles(2);

    // Bounce shorter than the debounce window: nothing happens
    btn_start_stop = 1'b1; cycles(2);
    btn_start_stop = 1'b0; cycles(1);
    btn_start_stop = 1'b1; cycles(2);
    btn_start_stop = 1'b0; cycles(10);
    check("bounce_state", state, 2'd0);

    // Start: state becomes RUN 7 edges after the rise (pulse visible at 6)
    btn_start_stop = 1'b1;
    wait_state(2'd1, 20, n);
    check("start_lat", n, 7);
    check("running", running, 1'b1);
    wait_en(20, n);
    check("first_tick", n, TICK - 1);  // count_en in the 4th cycle of RUN
    cycle();
    wait_en(20, n);
    check("tick_period", n + 1, TICK);
    btn_start_stop = 1'b0;
    cycles(8);

    // Lap hold and release; ticks continue under the model
    press(1);
    check("lap_state", state, 2'd2);
    check("lap_hold", display_hold, 1'b1);
    cycles(5);
    press(1);
    check("unlap_state", state, 2'd1);
    check("unlap_hold", display_hold, 1'b0);

    // Stop then resume; prescaler fraction is preserved
    press(0);
    check("stop_state", state, 2'd3);
    cycles(5);
    press(0);
    check("resume_state", state, 2'd1);
    cycles(3);
    press(0);
    check("stop2_state", state, 2'd3);

    // Clear and start_stop together in STOP: clear wins
    clr_seen = 0;
    btn_clear = 1'b1; btn_start_stop = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 6) begin btn_clear = 1'b0; btn_start_stop = 1'b0; end
      cycle();
      if (count_clr === 1'b1) clr_seen++;
    end
    check("clr_pulses", clr_seen, 1);
    check("clr_state", state, 2'd0);
    btn_start_stop = 1'b1;
    wait_state(2'd1, 20, n);
    check("restart_lat", n, 7);
    wait_en(20, n);
    check("restart_tick", n, TICK - 1);
    btn_start_stop = 1'b0;
    cycles(8);

    // Reset mid-prescale and mid-debounce of lap, lap still held afterwards
    btn_lap = 1'b1;
    cycles(3);
    reset = 1'b1;
    cycle();
    check("mid_reset", {count_en, count_clr, display_hold, running, state}, 6'b0);
    reset = 1'b0;
    cycles(15);
    check("post_reset_state", state, 2'd0);
    btn_lap = 1'b0;
    cycles(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Sequencing controller for the 4-digit BCD stopwatch counter. Conditions three raw push-buttons (synchronise, debounce, one-pulse), runs the run/stop/lap/clear state machine, and generates the counter's increment strobe from the system clock via a prescaler. Sits between board buttons and the counter; the counter increments only on count_en and zeroes on count_clr, and the display path freezes while display_hold is high.

Parameters:
TICK_DIV, 1000000, clk cycles per count_en pulse (100 MHz / 1e6 = 0.01 s tick); legal >= 2
DEB_CYCLES, 1000000, consecutive stable cycles needed to accept a button level change; legal >= 1
PRE_W, 20, prescaler width; must satisfy 2**PRE_W >= TICK_DIV
DEB_W, 20, debounce counter width; must satisfy 2**DEB_W > DEB_CYCLES

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
btn_start_stop  in  1  raw asynchronous button: toggles run/stop
btn_lap  in  1  raw asynchronous button: lap hold / release
btn_clear  in  1  raw asynchronous button: zero the count when stopped
count_en  out  1  one-cycle increment strobe to counter
count_clr  out  1  one-cycle clear strobe to counter
display_hold  out  1  freeze displayed value (lap)
running  out  1  high in RUN or LAP
state  out  2  FSM state: IDLE=0, RUN=1, LAP=2, STOP=3

Behaviour:
- Reset (synchronous, one clk edge with reset=1): state=IDLE, prescaler=0, all debounce counters=0, all stable levels=0, sync flops=0; count_en=0, count_clr=0, display_hold=0, running=0. Reset dominates all other activity, including a mid-debounce count or mid-prescale count.
- Button path, per button: 2-flop synchroniser -> debounce -> rising-edge detect. Debounce counter increments each cycle the synced level differs from the stable level, clears to 0 when they match; on reaching DEB_CYCLES the stable level takes the synced level and the counter clears. A press pulse (internal, one cycle) fires the cycle after stable goes 0->1. Release produces no pulse. Glitches shorter than DEB_CYCLES produce nothing.
- Latency, raw rise to press pulse: 2 + DEB_CYCLES + 1 cycles. A button held through reset yields exactly one press after debounce.
- Press priority when pulses coincide: clear > start_stop > lap. Only the highest-priority pulse that is valid in the current state acts; the rest are dropped.
- FSM transitions (registered; take effect at the edge after the press pulse):
  IDLE: start_stop -> RUN with prescaler=0; clear -> IDLE with count_clr pulse; lap ignored.
  RUN: start_stop -> STOP; lap -> LAP; clear ignored.
  LAP: start_stop -> STOP; lap -> RUN; clear ignored.
  STOP: start_stop -> RUN, prescaler kept (sub-tick fraction preserved); clear -> IDLE, prescaler=0, count_clr pulse; lap ignored.
- Prescaler: counts only in RUN or LAP. At value TICK_DIV-1 it wraps to 0 and count_en is high for that one cycle. count_en is never high in IDLE or STOP. The first tick after IDLE->RUN comes TICK_DIV cycles after entry.
- count_clr: registered, high for exactly the one cycle after the clear transition edge; never together with count_en.
- display_hold = (state==LAP); running = (state==RUN || state==LAP); both are decoded from the state register, no extra latency.

Test Plan:
(Bench uses TICK_DIV=4, DEB_CYCLES=3, default widths.)
1. Reset, then btn_start_stop high for 10 cycles -> press pulse 6 cycles after rise; state 0->1; count_en pulses every 4th cycle starting 4 cycles after entry; running=1.
2. Button bounce: btn_start_stop high 2 cycles, low 1, high 2, low -> no press, state stays IDLE, no count_en.
3. RUN, press lap -> state=2, display_hold=1, count_en continues at period 4; press lap again -> state=1, display_hold=0.
4. RUN at prescaler=2, press start_stop -> STOP, no count_en; press again -> RUN, first count_en 1 cycle after resume (prescaler 2->3).
5. STOP, clear and start_stop pulses in the same cycle -> clear wins: state=IDLE, count_clr high 1 cycle, prescaler=0; next start_stop gives first tick after 4 cycles.
6. RUN, assert reset for 1 cycle mid-prescale and mid-debounce of btn_lap -> all outputs 0, state=IDLE, no later lap press unless btn_lap is still high after a fresh 3-cycle debounce.
